ref_buf_from_axi_read_master: RTL and testbench
===============================================

// Module: ref_buf_from_axi_read_master
// PURPOSE
//  Fetches one reconstructed 8x8 luma block from the DPB in external memory over AXI4 read (AR/R).
//  Pairs with the DBF-side AXI write master and uses the same DPB tile layout (IU/BU offsets).
//  Accepts a block request (base address plus 8x8 X/Y coordinates) and issues one INCR burst.
//  Assembles the burst beats into one block word and hands it to the reference cache fill path.
// PARAMETERS
//  AXI_ADDR_WDTH   32       AXI address width
//  AXI_DATA_WDTH   512      AXI read data width
//  BEATS           2        beats per burst; ARLEN = BEATS-1
//  X_BLK_WDTH      8        width of 8x8-granular X/Y coordinate
//  CTU_BLK_BITS    3        log2(8x8 blocks per CTU side)
//  BU_OFFSET       128      byte stride between horizontally adjacent 8x8 blocks in a CTU
//  BU_ROW_OFFSET   1024     byte stride between 8x8 block rows in a CTU
//  IU_OFFSET       8192     byte stride between horizontally adjacent CTUs
//  IU_ROW_OFFSET   262144   byte stride between CTU rows
// PORTS
//  clk            in   1                       clock
//  reset          in   1                       synchronous, active-high reset
//  req_valid_in   in   1                       block request valid
//  req_ready_out  out  1                       request accepted when valid & ready
//  req_base_in    in   AXI_ADDR_WDTH           DPB base address of the target picture
//  req_x_in       in   X_BLK_WDTH              8x8 block X coordinate
//  req_y_in       in   X_BLK_WDTH              8x8 block Y coordinate
//  blk_valid_out  out  1                       assembled block valid
//  blk_ready_in   in   1                       consumer accepts the block
//  blk_data_out   out  BEATS*AXI_DATA_WDTH     block data; beat 0 in the LSBs
//  blk_err_out    out  1                       error flag qualified by blk_valid_out
//  axi_arid/arlen/arsize/arburst/arlock/arcache/arprot  out  1/8/3/2/1/4/3  constants
//                                              0, BEATS-1, log2(AXI_DATA_WDTH/8), INCR, 0, default, data
//  axi_araddr     out  AXI_ADDR_WDTH           burst start address
//  axi_arvalid    out  1                       address valid
//  axi_arready    in   1                       address ready
//  axi_rid        in   1                       read ID (ignored)
//  axi_rdata      in   AXI_DATA_WDTH           read data
//  axi_rresp      in   2                       read response
//  axi_rlast      in   1                       last beat of the burst
//  axi_rvalid     in   1                       read data valid
//  axi_rready     out  1                       read data ready
// BEHAVIOUR
//  - Reset values: arvalid=0, rready=0, blk_valid=0, blk_err=0, req_ready=0, beat_cnt=0, state=IDLE.
//    blk_data and araddr are don't-care after reset.
//  - Address computation:
//      x_blk = x[CTU_BLK_BITS-1:0]; x_ctu = x[X_BLK_WDTH-1:CTU_BLK_BITS] (y likewise).
//      araddr = base + y_ctu*IU_ROW_OFFSET + x_ctu*IU_OFFSET + y_blk*BU_ROW_OFFSET + x_blk*BU_OFFSET
//    Result is truncated modulo 2^AXI_ADDR_WDTH. It is registered on request acceptance.
//  - One outstanding burst. The FSM is IDLE -> AR_SEND -> R_COLLECT -> OUT -> IDLE.
//  - IDLE: req_ready=1 (combinational on state). On req_valid, latch the address and go to AR_SEND.
//    arvalid rises on the next cycle.
//  - AR_SEND: arvalid=1. araddr is held stable until arready. On arready, drop arvalid,
//    clear beat_cnt and go to R_COLLECT.
//  - R_COLLECT: rready=1. Each rvalid beat is written to slot beat_cnt and beat_cnt increments.
//    Beats with beat_cnt>=BEATS are discarded.
//    On rvalid&rlast go to OUT (blk_valid=1 next cycle).
//    blk_err is set if any beat has rresp[1]=1, or if rlast arrives with beat_cnt!=BEATS-1.
//  - OUT: blk_valid=1; data and err are stable until blk_ready. On blk_ready, clear blk_valid
//    and blk_err and go to IDLE. There is no same-cycle bypass, so req_ready returns the cycle after.
//  - Minimum latency: request accept -> arvalid is 1 cycle. Last R beat -> blk_valid is 1 cycle.
//  - Reset mid-burst forces IDLE immediately. The interconnect must be reset together with the block.
//    R beats arriving after reset are not accepted (rready=0).
// CONFIGURATION
//  REF_RD_RETRY_EN defined:
//    - An error burst is not delivered. On rlast the FSM returns to AR_SEND with the same araddr.
//    - Retry is unlimited. blk_err_out is tied to 0.
//  REF_RD_RETRY_EN undefined:
//    - The block is always delivered, with blk_err_out=1 when the burst had an error.
// TESTING
//  1. req x=0,y=0,base=0x1000_0000 -> araddr=0x1000_0000, arlen=1.
//     2 beats A,B -> blk_data={B,A}, err=0.
//  2. req x=9,y=10,base=0 -> araddr = 1*262144 + 1*8192 + 2*1024 + 1*128 = 0x4_2880.
//  3. arready held low for 5 cycles -> arvalid and araddr stable. rvalid gaps of 3 cycles
//     between beats -> correct assembly.
//  4. blk_ready low for 4 cycles, with a new req_valid waiting -> req_ready=0 throughout.
//     Block accepted -> req_ready=1 the next cycle.
//  5. Beat 0 rresp=2'b10:
//     no macro -> blk_err=1;
//     with REF_RD_RETRY_EN -> second AR to the same address, then clean data with err=0.
//  6. rlast on beat 0 -> err=1. Reset asserted in R_COLLECT -> arvalid=rready=blk_valid=0
//     the next cycle, req_ready=1 after reset release.

Source files
------------

// File: rtl/ref_buf_from_axi_read_master.sv
// Reference-block fetcher: one 8x8 luma block per request, fetched from the DPB tile layout as a single AXI4 INCR read burst.
// Optional macro REF_RD_RETRY_EN: an errored burst is re-issued to the same address and is never delivered.
module ref_buf_from_axi_read_master #(
    parameter int AXI_ADDR_WDTH = 32,
    parameter int AXI_DATA_WDTH = 512,
    parameter int BEATS         = 2,
    parameter int X_BLK_WDTH    = 8,
    parameter int CTU_BLK_BITS  = 3,
    parameter int BU_OFFSET     = 128,
    parameter int BU_ROW_OFFSET = 1024,
    parameter int IU_OFFSET     = 8192,
    parameter int IU_ROW_OFFSET = 262144
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid_in,
    output logic                             req_ready_out,
    input  logic [AXI_ADDR_WDTH-1:0]         req_base_in,
    input  logic [X_BLK_WDTH-1:0]            req_x_in,
    input  logic [X_BLK_WDTH-1:0]            req_y_in,
    output logic                             blk_valid_out,
    input  logic                             blk_ready_in,
    output logic [BEATS*AXI_DATA_WDTH-1:0]   blk_data_out,
    output logic                             blk_err_out,
    output logic                             axi_arid,
    output logic [7:0]                       axi_arlen,
    output logic [2:0]                       axi_arsize,
    output logic [1:0]                       axi_arburst,
    output logic                             axi_arlock,
    output logic [3:0]                       axi_arcache,
    output logic [2:0]                       axi_arprot,
    output logic [AXI_ADDR_WDTH-1:0]         axi_araddr,
    output logic                             axi_arvalid,
    input  logic                             axi_arready,
    input  logic                             axi_rid,
    input  logic [AXI_DATA_WDTH-1:0]         axi_rdata,
    input  logic [1:0]                       axi_rresp,
    input  logic                             axi_rlast,
    input  logic                             axi_rvalid,
    output logic                             axi_rready
);

    localparam int CNT_WDTH = $clog2(BEATS + 1);
    localparam logic [CNT_WDTH-1:0] LAST_IDX = CNT_WDTH'(BEATS - 1);
    localparam logic [CNT_WDTH-1:0] CNT_SAT  = CNT_WDTH'(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        AR_SEND,
        R_COLLECT,
        OUT
    } state_t;

    state_t                           r_state;
    state_t                           w_next_state;
    logic [AXI_ADDR_WDTH-1:0]         r_araddr;
    logic [CNT_WDTH-1:0]              r_beat_cnt;
    logic                             r_err;
    logic [BEATS*AXI_DATA_WDTH-1:0]   r_data;

    logic [CTU_BLK_BITS-1:0]              w_x_blk;
    logic [CTU_BLK_BITS-1:0]              w_y_blk;
    logic [X_BLK_WDTH-CTU_BLK_BITS-1:0]   w_x_ctu;
    logic [X_BLK_WDTH-CTU_BLK_BITS-1:0]   w_y_ctu;
    logic [AXI_ADDR_WDTH-1:0]             w_req_addr;
    logic                                 w_req_fire;
    logic                                 w_ar_fire;
    logic                                 w_r_fire;
    logic                                 w_blk_fire;
    logic                                 w_beat_err;
    logic                                 w_burst_err;
    logic                                 w_unused_inputs;

    // CTU (IU) and 8x8 (BU) components of the coordinates select the tile inside the DPB picture.
    assign w_x_blk = req_x_in[CTU_BLK_BITS-1:0];
    assign w_y_blk = req_y_in[CTU_BLK_BITS-1:0];
    assign w_x_ctu = req_x_in[X_BLK_WDTH-1:CTU_BLK_BITS];
    assign w_y_ctu = req_y_in[X_BLK_WDTH-1:CTU_BLK_BITS];

    assign w_req_addr = req_base_in
                      + AXI_ADDR_WDTH'(w_y_ctu) * AXI_ADDR_WDTH'(IU_ROW_OFFSET)
                      + AXI_ADDR_WDTH'(w_x_ctu) * AXI_ADDR_WDTH'(IU_OFFSET)
                      + AXI_ADDR_WDTH'(w_y_blk) * AXI_ADDR_WDTH'(BU_ROW_OFFSET)
                      + AXI_ADDR_WDTH'(w_x_blk) * AXI_ADDR_WDTH'(BU_OFFSET);

    assign req_ready_out = (r_state == IDLE) && !reset;
    assign axi_arvalid   = (r_state == AR_SEND);
    assign axi_rready    = (r_state == R_COLLECT);
    assign blk_valid_out = (r_state == OUT);
    assign axi_araddr    = r_araddr;
    assign blk_data_out  = r_data;

    assign axi_arid    = 1'b0;
    assign axi_arlen   = 8'(BEATS - 1);
    assign axi_arsize  = 3'($clog2(AXI_DATA_WDTH / 8));
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = 4'b0011;
    assign axi_arprot  = 3'b000;

    assign w_req_fire  = req_valid_in && req_ready_out;
    assign w_ar_fire   = axi_arvalid && axi_arready;
    assign w_r_fire    = axi_rvalid && axi_rready;
    assign w_blk_fire  = blk_valid_out && blk_ready_in;

    // A short burst (rlast before the final slot) is as much an error as a SLVERR/DECERR response.
    assign w_beat_err  = axi_rresp[1] || (axi_rlast && (r_beat_cnt != LAST_IDX));
    assign w_burst_err = r_err || w_beat_err;

    assign w_unused_inputs = ^{axi_rid, axi_rresp[0]};

`ifdef REF_RD_RETRY_EN
    assign blk_err_out = 1'b0;
`else
    assign blk_err_out = (r_state == OUT) && r_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_next_state = AR_SEND;
                end
            end
            AR_SEND: begin
                if (axi_arready) begin
                    w_next_state = R_COLLECT;
                end
            end
            R_COLLECT: begin
                if (axi_rvalid && axi_rlast) begin
`ifdef REF_RD_RETRY_EN
                    w_next_state = w_burst_err ? AR_SEND : OUT;
`else
                    w_next_state = OUT;
`endif
                end
            end
            OUT: begin
                if (blk_ready_in) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The beat counter saturates so that over-long bursts still read as mis-sized at rlast.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_ar_fire) begin
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_r_fire) begin
            if (r_beat_cnt != CNT_SAT) begin
                r_beat_cnt <= r_beat_cnt + CNT_WDTH'(1);
            end
            r_err <= w_burst_err;
        end else if (w_blk_fire) begin
            r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_araddr <= w_req_addr;
        end
        if (w_r_fire && (r_beat_cnt < CNT_SAT)) begin
            r_data[int'(r_beat_cnt)*AXI_DATA_WDTH +: AXI_DATA_WDTH] <= axi_rdata;
        end
    end

endmodule

// File: tb/tb_ref_buf_from_axi_read_master.sv
// Bench for ref_buf_from_axi_read_master: directed AXI read traffic, a handshake-level reference model
// checked every cycle, and literal expectations for the hand-computed addresses and blocks.
module tb_ref_buf_from_axi_read_master;

    localparam int AW    = 32;
    localparam int DW    = 512;
    localparam int BEATS = 2;
    localparam int BW    = BEATS * DW;
    localparam int TMO   = 200;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid_in = 1'b0;
    logic            req_ready_out;
    logic [AW-1:0]   req_base_in = '0;
    logic [7:0]      req_x_in = '0;
    logic [7:0]      req_y_in = '0;
    logic            blk_valid_out;
    logic            blk_ready_in = 1'b0;
    logic [BW-1:0]   blk_data_out;
    logic            blk_err_out;
    logic            axi_arid;
    logic [7:0]      axi_arlen;
    logic [2:0]      axi_arsize;
    logic [1:0]      axi_arburst;
    logic            axi_arlock;
    logic [3:0]      axi_arcache;
    logic [2:0]      axi_arprot;
    logic [AW-1:0]   axi_araddr;
    logic            axi_arvalid;
    logic            axi_arready = 1'b0;
    logic            axi_rid = 1'b0;
    logic [DW-1:0]   axi_rdata = '0;
    logic [1:0]      axi_rresp = 2'b00;
    logic            axi_rlast = 1'b0;
    logic            axi_rvalid = 1'b0;
    logic            axi_rready;

    int numCompared = 0;
    int numMismatched = 0;

    always #5 clk = ~clk;

    ref_buf_from_axi_read_master dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_base_in(req_base_in), .req_x_in(req_x_in), .req_y_in(req_y_in),
        .blk_valid_out(blk_valid_out), .blk_ready_in(blk_ready_in),
        .blk_data_out(blk_data_out), .blk_err_out(blk_err_out),
        .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        numCompared++;
        numMismatched++;
        $display("[TB] FAIL %s: event not seen, required within %0d cycles", name, TMO);
    endtask

    function automatic logic [DW-1:0] mkBeat(input logic [31:0] w);
        return {16{w}};
    endfunction

    // Tile address straight from the picture layout: CTU rows/columns, then 8x8 rows/columns inside the CTU.
    function automatic logic [AW-1:0] blockAddr(input logic [AW-1:0] base, input logic [7:0] x, input logic [7:0] y);
        longint sum;
        sum = longint'(base) + longint'(y / 8) * 262144 + longint'(x / 8) * 8192
            + longint'(y % 8) * 1024 + longint'(x % 8) * 128;
        return AW'(sum);
    endfunction

    // Reference model: which phase of the single outstanding transaction we are in, and what it must carry.
    bit            busy = 0;
    bit            arDone = 0;
    bit            haveBlk = 0;
    bit            prevReset = 0;
    bit            burstErr = 0;
    bit            expErr = 0;
    int            beatCnt = 0;
    int            expBeats = 0;
    logic [AW-1:0] expAddr = '0;
    logic [BW-1:0] colData = '0;
    logic [BW-1:0] expData = '0;

    always @(negedge clk) begin
        if (reset) begin
            if (prevReset) begin
                checkOutput("rst_req_ready", req_ready_out, 0);
                checkOutput("rst_arvalid", axi_arvalid, 0);
                checkOutput("rst_rready", axi_rready, 0);
                checkOutput("rst_blk_valid", blk_valid_out, 0);
                checkOutput("rst_blk_err", blk_err_out, 0);
            end
            busy = 0;
            arDone = 0;
            haveBlk = 0;
        end else begin
            checkOutput("req_ready", req_ready_out, !busy);
            checkOutput("arvalid", axi_arvalid, busy && !arDone);
            checkOutput("rready", axi_rready, busy && arDone && !haveBlk);
            checkOutput("blk_valid", blk_valid_out, haveBlk);
            if (axi_arvalid && busy && !arDone) begin
                checkOutput("araddr", axi_araddr, expAddr);
                checkOutput("arlen", axi_arlen, 8'd1);
                checkOutput("arsize", axi_arsize, 3'd6);
                checkOutput("arburst", axi_arburst, 2'b01);
                checkOutput("arid", axi_arid, 0);
                checkOutput("arlock", axi_arlock, 0);
                checkOutput("arcache", axi_arcache, 4'b0011);
                checkOutput("arprot", axi_arprot, 3'b000);
            end
            if (blk_valid_out && haveBlk) begin
                for (int i = 0; i < BEATS; i++) begin
                    if (i < expBeats) begin
                        checkOutput($sformatf("blk_data_beat%0d", i), blk_data_out[i*DW +: DW], expData[i*DW +: DW]);
                    end
                end
                checkOutput("blk_err", blk_err_out, expErr);
            end

            if (req_valid_in && req_ready_out) begin
                busy = 1;
                arDone = 0;
                haveBlk = 0;
                expAddr = blockAddr(req_base_in, req_x_in, req_y_in);
            end
            if (axi_arvalid && axi_arready) begin
                arDone = 1;
                beatCnt = 0;
                burstErr = 0;
                colData = '0;
            end
            if (axi_rvalid && axi_rready) begin
                if (beatCnt < BEATS) begin
                    colData[beatCnt*DW +: DW] = axi_rdata;
                end
                beatCnt++;
                if (axi_rresp[1]) burstErr = 1;
                if (axi_rlast) begin
                    if (beatCnt != BEATS) burstErr = 1;
`ifdef REF_RD_RETRY_EN
                    if (burstErr) begin
                        arDone = 0;
                    end else begin
                        haveBlk = 1;
                        expData = colData;
                        expBeats = beatCnt;
                        expErr = 0;
                    end
`else
                    haveBlk = 1;
                    expData = colData;
                    expBeats = (beatCnt < BEATS) ? beatCnt : BEATS;
                    expErr = burstErr;
`endif
                end
            end
            if (blk_valid_out && blk_ready_in) begin
                busy = 0;
                haveBlk = 0;
            end
        end
        prevReset = reset;
    end

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        req_valid_in = 1'b1;
        req_base_in = base;
        req_x_in = x;
        req_y_in = y;
        do begin @(negedge clk); n++; end while (!req_ready_out && n < TMO);
        if (!req_ready_out) reportTimeout("req_ready_wait");
        @(posedge clk); #1;
        req_valid_in = 1'b0;
    endtask

    task automatic serveAr(input int stall, input string name, input logic [AW-1:0] addr);
        int n = 0;
        do begin @(negedge clk); n++; end while (!axi_arvalid && n < TMO);
        if (!axi_arvalid) reportTimeout({name, "_arvalid_wait"});
        else begin
            checkOutput(name, axi_araddr, addr);
            checkOutput({name, "_arlen"}, axi_arlen, 8'd1);
        end
        repeat (stall) @(posedge clk);
        #1 axi_arready = 1'b1;
        @(posedge clk); #1;
        axi_arready = 1'b0;
    endtask

    task automatic sendBeat(input logic [DW-1:0] data, input logic [1:0] resp, input logic last, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        axi_rvalid = 1'b1;
        axi_rdata = data;
        axi_rresp = resp;
        axi_rlast = last;
        do begin @(negedge clk); n++; end while (!axi_rready && n < TMO);
        if (!axi_rready) reportTimeout("rready_wait");
        @(posedge clk); #1;
        axi_rvalid = 1'b0;
        axi_rlast = 1'b0;
        axi_rresp = 2'b00;
    endtask

    task automatic takeBlock(input int hold, input string name, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                             input bit checkHi, input logic err);
        int n = 0;
        do begin @(negedge clk); n++; end while (!blk_valid_out && n < TMO);
        if (!blk_valid_out) reportTimeout({name, "_blk_wait"});
        else begin
            checkOutput({name, "_lo"}, blk_data_out[DW-1:0], lo);
            if (checkHi) checkOutput({name, "_hi"}, blk_data_out[BW-1:DW], hi);
            checkOutput({name, "_err"}, blk_err_out, err);
        end
        repeat (hold) @(posedge clk);
        #1 blk_ready_in = 1'b1;
        @(posedge clk); #1;
        blk_ready_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required before 2000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("init_req_ready", req_ready_out, 0);
        checkOutput("init_blk_valid", blk_valid_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("init_rel_req_ready", req_ready_out, 1);
        @(posedge clk); #1;

        $display("[TB] test 1: origin block");
        applyStimulus(32'h1000_0000, 8'd0, 8'd0);
        serveAr(1, "t1_araddr", 32'h1000_0000);
        sendBeat(mkBeat(32'hAAAA_0001), 2'b00, 1'b0, 0);
        sendBeat(mkBeat(32'hBBBB_0002), 2'b00, 1'b1, 0);
        takeBlock(1, "t1", mkBeat(32'hAAAA_0001), mkBeat(32'hBBBB_0002), 1, 1'b0);

        $display("[TB] test 2: x=9 y=10");
        applyStimulus(32'h0, 8'd9, 8'd10);
        serveAr(1, "t2_araddr", 32'h0004_2880);
        sendBeat(mkBeat(32'hCCCC_0003), 2'b00, 1'b0, 0);
        sendBeat(mkBeat(32'hDDDD_0004), 2'b00, 1'b1, 0);
        takeBlock(1, "t2", mkBeat(32'hCCCC_0003), mkBeat(32'hDDDD_0004), 1, 1'b0);

        $display("[TB] test 3: arready stall and rvalid gaps");
        applyStimulus(32'h2000_0000, 8'd35, 8'd15);
        serveAr(5, "t3_araddr", 32'h2004_9D80);
        sendBeat(mkBeat(32'h1234_5678), 2'b00, 1'b0, 3);
        sendBeat(mkBeat(32'h9ABC_DEF0), 2'b01, 1'b1, 3);
        takeBlock(1, "t3", mkBeat(32'h1234_5678), mkBeat(32'h9ABC_DEF0), 1, 1'b0);

        $display("[TB] test 4: block backpressure with a waiting request");
        applyStimulus(32'h0, 8'd1, 8'd0);
        serveAr(1, "t4_araddr", 32'h0000_0080);
        sendBeat(mkBeat(32'h4444_0001), 2'b00, 1'b0, 0);
        sendBeat(mkBeat(32'h4444_0002), 2'b00, 1'b1, 0);
        req_valid_in = 1'b1;
        req_base_in = 32'hFFFF_0000;
        req_x_in = 8'hFF;
        req_y_in = 8'hFF;
        @(negedge clk);
        checkOutput("t4_req_ready_busy", req_ready_out, 0);
        @(posedge clk); #1;
        takeBlock(4, "t4", mkBeat(32'h4444_0001), mkBeat(32'h4444_0002), 1, 1'b0);
        @(negedge clk);
        checkOutput("t4_req_ready_after", req_ready_out, 1);
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        serveAr(1, "t4b_araddr_wrap", 32'h007E_FF80);
        sendBeat(mkBeat(32'h5555_0001), 2'b00, 1'b0, 0);
        sendBeat(mkBeat(32'h5555_0002), 2'b00, 1'b1, 0);
        takeBlock(1, "t4b", mkBeat(32'h5555_0001), mkBeat(32'h5555_0002), 1, 1'b0);

        $display("[TB] test 5: SLVERR on beat 0");
        applyStimulus(32'h3000_0000, 8'd2, 8'd3);
        serveAr(1, "t5_araddr", 32'h3000_0D00);
        sendBeat(mkBeat(32'h6666_0001), 2'b10, 1'b0, 0);
        sendBeat(mkBeat(32'h6666_0002), 2'b00, 1'b1, 0);
`ifdef REF_RD_RETRY_EN
        serveAr(1, "t5_retry_araddr", 32'h3000_0D00);
        sendBeat(mkBeat(32'h7777_0001), 2'b00, 1'b0, 0);
        sendBeat(mkBeat(32'h7777_0002), 2'b00, 1'b1, 1);
        takeBlock(1, "t5", mkBeat(32'h7777_0001), mkBeat(32'h7777_0002), 1, 1'b0);
`else
        takeBlock(1, "t5", mkBeat(32'h6666_0001), mkBeat(32'h6666_0002), 1, 1'b1);
`endif

        $display("[TB] test 6: early rlast");
        applyStimulus(32'h4000_0000, 8'd8, 8'd8);
        serveAr(1, "t6_araddr", 32'h4004_2000);
        sendBeat(mkBeat(32'h8888_0001), 2'b00, 1'b1, 0);
`ifdef REF_RD_RETRY_EN
        serveAr(1, "t6_retry_araddr", 32'h4004_2000);
        sendBeat(mkBeat(32'h9999_0001), 2'b00, 1'b0, 0);
        sendBeat(mkBeat(32'h9999_0002), 2'b00, 1'b1, 0);
        takeBlock(1, "t6", mkBeat(32'h9999_0001), mkBeat(32'h9999_0002), 1, 1'b0);
`else
        takeBlock(1, "t6", mkBeat(32'h8888_0001), '0, 0, 1'b1);
`endif

        $display("[TB] test 6b: reset during read collection");
        applyStimulus(32'h5000_0000, 8'd0, 8'd1);
        serveAr(1, "t6b_araddr", 32'h5000_0400);
        @(negedge clk);
        checkOutput("t6b_rready_collect", axi_rready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        axi_rvalid = 1'b1;
        axi_rdata = mkBeat(32'hDEAD_BEEF);
        axi_rlast = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6b_arvalid_rst", axi_arvalid, 0);
        checkOutput("t6b_rready_rst", axi_rready, 0);
        checkOutput("t6b_blk_valid_rst", blk_valid_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t6b_req_ready_rel", req_ready_out, 1);
        checkOutput("t6b_rready_rel", axi_rready, 0);
        @(posedge clk); #1;
        axi_rvalid = 1'b0;
        axi_rlast = 1'b0;

        $display("[TB] test 7: recovery after reset");
        applyStimulus(32'h0000_0040, 8'd7, 8'd7);
        serveAr(2, "t7_araddr", 32'h0000_1FC0);
        sendBeat(mkBeat(32'hABCD_0001), 2'b00, 1'b0, 1);
        sendBeat(mkBeat(32'hABCD_0002), 2'b00, 1'b1, 0);
        takeBlock(2, "t7", mkBeat(32'hABCD_0001), mkBeat(32'hABCD_0002), 1, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
